// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module : spi_pkg
// Purpose: Shared types and constants for the parametrised SPI master.
//          Provides the transfer FSM state type, the four SPI mode codes
//          packed as {CPOL,CPHA}, and a helper to size the select index.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    XFER  = 2'd2,
    TRAIL = 2'd3
  } spi_state_e;

  // Mode codes as {CPOL,CPHA}
  localparam logic [1:0] c_MODE0 = 2'b00;
  localparam logic [1:0] c_MODE1 = 2'b01;
  localparam logic [1:0] c_MODE2 = 2'b10;
  localparam logic [1:0] c_MODE3 = 2'b11;

  // Select-index width; a single slave still needs a 1-bit index port.
  function automatic int ss_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_master_param_if.sv
`default_nettype none
// ============================================================================
// Module : spi_master_param_if
// Purpose: Control handshake plus serial bus of the SPI master.
// Ports  : START/SS_IN/CPOL/CPHA/CLK_DIV/DATA_M - transfer request and setup
//          MISO                                 - serial data from slave
//          SCLK/MOSI/SS_N                       - serial bus to slaves
//          DATA_RX/BUSY/DONE/SEL_ERR            - result and status
//          modport master: view of the SPI master
//          modport slave : view of the controller / bus partner
// Rev    : 1.0  initial release
// ============================================================================
interface spi_master_param_if import spi_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 3,
  parameter int SS_W   = ss_width(NUM_SS),
  parameter int DIV_W  = 8
);

  logic              START;
  logic [SS_W-1:0]   SS_IN;
  logic              CPOL;
  logic              CPHA;
  logic [DIV_W-1:0]  CLK_DIV;
  logic [DATA_W-1:0] DATA_M;
  logic              MISO;
  logic              SCLK;
  logic              MOSI;
  logic [NUM_SS-1:0] SS_N;
  logic [DATA_W-1:0] DATA_RX;
  logic              BUSY;
  logic              DONE;
  logic              SEL_ERR;

  modport master (
    input  START, SS_IN, CPOL, CPHA, CLK_DIV, DATA_M, MISO,
    output SCLK, MOSI, SS_N, DATA_RX, BUSY, DONE, SEL_ERR
  );

  modport slave (
    output START, SS_IN, CPOL, CPHA, CLK_DIV, DATA_M, MISO,
    input  SCLK, MOSI, SS_N, DATA_RX, BUSY, DONE, SEL_ERR
  );

endinterface
`default_nettype wire

// File: rtl/spi_clk_gen.sv
`default_nettype none
// ============================================================================
// Module : spi_clk_gen
// Purpose: Half-period tick generator. Down-counter reloaded with the divider
//          value; ticks once every i_div+1 enabled cycles.
// Ports  : CLK, RST_N - clock, async active-low reset
//          i_load     - preload counter with i_div (frame accept)
//          i_en       - count while a transfer is active
//          i_div      - half-period minus one
//          o_tick     - one-cycle half-period tick
// Rev    : 1.0  initial release
// ============================================================================
module spi_clk_gen #(
  parameter int DIV_W = 8
) (
  input  wire logic             CLK,
  input  wire logic             RST_N,
  input  wire logic             i_load,
  input  wire logic             i_en,
  input  wire logic [DIV_W-1:0] i_div,
  output logic                  o_tick
);

  logic [DIV_W-1:0] r_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_div;
    end else if (i_en) begin
      r_cnt <= (r_cnt == '0) ? i_div : r_cnt - 1'b1;
    end
  end

  assign o_tick = i_en && (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/spi_master_param.sv
`default_nettype none
// ============================================================================
// Module : spi_master_param
// Purpose: Parametrised SPI master. One DATA_W-bit MSB-first frame per accepted
//          START, any CPOL/CPHA mode, programmable SCLK half-period, one of
//          NUM_SS active-low selects.
// Ports  : CLK   - system clock (rising edge)
//          RST_N - asynchronous active-low reset
//          bus   - spi_master_param_if.master (request, serial bus, status)
// Rev    : 1.0  initial release
// ============================================================================
module spi_master_param import spi_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 3,
  parameter int SS_W   = ss_width(NUM_SS),
  parameter int DIV_W  = 8
) (
  input wire logic           CLK,
  input wire logic           RST_N,
  spi_master_param_if.master bus
);

  localparam int                c_EDGE_W    = $clog2(2 * DATA_W + 1);
  localparam logic [c_EDGE_W-1:0] c_LAST_EDGE = c_EDGE_W'(2 * DATA_W);

  spi_state_e          r_state, w_state_nxt;
  logic                r_cpol, r_cpha;
  logic [DIV_W-1:0]    r_div;
  logic [DATA_W-1:0]   r_tx, r_rx, r_data_rx;
  logic [c_EDGE_W-1:0] r_edge;
  logic [NUM_SS-1:0]   r_ss_n;
  logic                r_sclk, r_mosi, r_busy, r_done, r_sel_err;

  logic                w_tick, w_accept, w_sel_err, w_xfer_tick, w_finish;
  logic                w_valid_ss, w_leading, w_sample_lead, w_sample, w_shift;
  logic [c_EDGE_W-1:0] w_edge_num;
  logic [DIV_W-1:0]    w_div;

  // Divider value comes straight from the port on accept, from the latch after.
  assign w_div = w_accept ? bus.CLK_DIV : r_div;

  spi_clk_gen #(.DIV_W(DIV_W)) u_clk_gen (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .i_load (w_accept),
    .i_en   (r_state != IDLE),
    .i_div  (w_div),
    .o_tick (w_tick)
  );

  assign w_valid_ss    = int'(bus.SS_IN) < NUM_SS;
  // Number of the SCLK edge produced by the current tick; odd = leading.
  assign w_edge_num    = r_edge + 1'b1;
  assign w_leading     = w_edge_num[0];
  assign w_sample_lead = ({r_cpol, r_cpha} == c_MODE0) || ({r_cpol, r_cpha} == c_MODE2);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_sel_err   = 1'b0;
    w_xfer_tick = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        w_accept  = bus.START && w_valid_ss;
        w_sel_err = bus.START && !w_valid_ss;
        if (w_accept) w_state_nxt = LEAD;
      end
      LEAD: begin
        if (w_tick) w_state_nxt = XFER;
      end
      XFER: begin
        w_xfer_tick = w_tick;
        if (w_tick && (w_edge_num == c_LAST_EDGE)) w_state_nxt = TRAIL;
      end
      TRAIL: begin
        w_finish = w_tick;
        if (w_tick) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // CPHA=0: sample on leading, advance MOSI on trailing (not after the last
  // edge, so MOSI keeps the LSB). CPHA=1: drive on leading, sample on trailing.
  assign w_sample = w_xfer_tick && (w_leading == w_sample_lead);
  assign w_shift  = w_xfer_tick &&
                    (w_sample_lead ? (!w_leading && (w_edge_num != c_LAST_EDGE)) : w_leading);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cpol    <= 1'b0;
      r_cpha    <= 1'b0;
      r_div     <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_data_rx <= '0;
      r_edge    <= '0;
      r_ss_n    <= '1;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sel_err <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_sel_err <= w_sel_err;
      if (w_accept) begin
        r_cpol <= bus.CPOL;
        r_cpha <= bus.CPHA;
        r_div  <= bus.CLK_DIV;
        r_edge <= '0;
        r_busy <= 1'b1;
        r_ss_n <= ~(NUM_SS'(1) << bus.SS_IN);
        r_sclk <= bus.CPOL;
        if (!bus.CPHA) begin
          // MSB must already be on the wire before the first leading edge.
          r_mosi <= bus.DATA_M[DATA_W-1];
          r_tx   <= bus.DATA_M << 1;
        end else begin
          r_tx   <= bus.DATA_M;
        end
      end
      if (w_xfer_tick) begin
        r_edge <= w_edge_num;
        r_sclk <= ~r_sclk;
      end
      if (w_shift) begin
        r_mosi <= r_tx[DATA_W-1];
        r_tx   <= r_tx << 1;
      end
      if (w_sample) begin
        r_rx <= {r_rx[DATA_W-2:0], bus.MISO};
      end
      if (w_finish) begin
        r_ss_n    <= '1;
        r_busy    <= 1'b0;
        r_done    <= 1'b1;
        r_data_rx <= r_rx;
      end
    end
  end

  assign bus.SCLK    = r_sclk;
  assign bus.MOSI    = r_mosi;
  assign bus.SS_N    = r_ss_n;
  assign bus.DATA_RX = r_data_rx;
  assign bus.BUSY    = r_busy;
  assign bus.DONE    = r_done;
  assign bus.SEL_ERR = r_sel_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_param.sv
`default_nettype none
// ============================================================================
// Module : tb_spi_master_param
// Purpose: Self-checking bench for spi_master_param. Table of frame vectors
//          (fixed + random) checked against a frame-level model, an SPI slave
//          model that counts SCLK edges, plus hand-written sequences for
//          select error, back-to-back frames and mid-frame reset.
// Ports  : none
// Rev    : 1.0  initial release
// ============================================================================
module tb_spi_master_param;
  import spi_pkg::*;

  localparam int DW   = 8;
  localparam int NSS  = 3;
  localparam int SSW  = ss_width(NSS);
  localparam int DIVW = 8;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  spi_master_param_if #(.DATA_W(DW), .NUM_SS(NSS), .SS_W(SSW), .DIV_W(DIVW)) bus ();

  spi_master_param #(.DATA_W(DW), .NUM_SS(NSS), .SS_W(SSW), .DIV_W(DIVW)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- frame vectors and reference model ----------------
  typedef struct {
    logic            cpol;
    logic            cpha;
    logic [DIVW-1:0] div;
    logic [SSW-1:0]  ss;
    logic [DW-1:0]   data_m;
    logic [DW-1:0]   slave_w;
    logic            loop;
    logic [DW-1:0]   exp_rx;
    int              exp_busy;
    logic [NSS-1:0]  exp_ssn;
  } vec_t;

  function automatic vec_t mk(input logic cpol, input logic cpha, input int div, input int ss,
                              input logic [DW-1:0] data, input logic [DW-1:0] slave,
                              input logic loop);
    vec_t v;
    v.cpol     = cpol;
    v.cpha     = cpha;
    v.div      = DIVW'(div);
    v.ss       = SSW'(ss);
    v.data_m   = data;
    v.slave_w  = slave;
    v.loop     = loop;
    v.exp_rx   = loop ? data : slave;
    v.exp_busy = (2 * DW + 2) * (div + 1);
    v.exp_ssn  = '1;
    v.exp_ssn[ss] = 1'b0;
    return v;
  endfunction

  // ---------------- SPI slave model ----------------
  logic          cur_cpha = 1'b0;
  logic          r_loop   = 1'b0;
  logic [DW-1:0] s_word   = '0;
  logic [DW-1:0] s_rx     = '0;
  logic          s_miso   = 1'b0;
  logic          s_sel    = 1'b0;
  logic          s_prev_sclk = 1'b0;
  logic          s_prev_mosi = 1'b0;
  int            s_e = 0, s_samples = 0, s_unstable = 0, s_idx = 0;
  logic [DW-1:0] s_q[$];
  int            s_cnt_q[$];

  assign bus.MISO = r_loop ? bus.MOSI : s_miso;

  always @(negedge CLK) begin
    if (&bus.SS_N) begin
      if (s_sel) begin
        s_q.push_back(s_rx);
        s_cnt_q.push_back(s_samples);
      end
      s_sel = 1'b0;
      s_e   = 0;
    end else begin
      if (!s_sel) begin
        s_sel = 1'b1;
        s_e = 0;
        s_rx = '0;
        s_samples = 0;
        s_prev_sclk = bus.SCLK;
      end else if (bus.SCLK !== s_prev_sclk) begin
        s_prev_sclk = bus.SCLK;
        s_e++;
        if (((s_e % 2) == 1) != cur_cpha) begin
          s_rx = {s_rx[DW-2:0], bus.MOSI};
          s_samples++;
          if (bus.MOSI !== s_prev_mosi) s_unstable++;
        end
      end
      s_idx = cur_cpha ? ((s_e > 0) ? (s_e - 1) / 2 : 0) : s_e / 2;
      if (s_idx > DW - 1) s_idx = DW - 1;
      s_miso = s_word[DW-1-s_idx];
    end
    s_prev_mosi = bus.MOSI;
  end

  // ---------------- one frame from a vector ----------------
  task automatic run_vec(input vec_t v, input int id);
    int busy_n = 0, ssn_bad = 0, selerr_n = 0;
    bit got_done = 0;
    string t;
    t = $sformatf("v%0d", id);
    @(negedge CLK);
    bus.CPOL = v.cpol; bus.CPHA = v.cpha; bus.CLK_DIV = v.div;
    bus.SS_IN = v.ss; bus.DATA_M = v.data_m; bus.START = 1'b1;
    cur_cpha = v.cpha; s_word = v.slave_w; r_loop = v.loop; s_unstable = 0;
    @(negedge CLK);
    bus.START = 1'b0;
    // Inputs changed after accept must not affect the frame.
    bus.DATA_M = ~v.data_m; bus.CPOL = ~v.cpol; bus.CPHA = ~v.cpha;
    bus.CLK_DIV = DIVW'($urandom); bus.SS_IN = SSW'($urandom_range(0, 3));
    for (int cyc = 0; cyc < 400 && !got_done; cyc++) begin
      if (bus.DONE) begin
        got_done = 1;
      end else begin
        if (bus.BUSY) busy_n++;
        if (bus.SS_N !== v.exp_ssn) ssn_bad++;
        if (bus.SEL_ERR) selerr_n++;
        bus.START = (cyc >= 2 && cyc < 5);
        @(negedge CLK);
      end
    end
    bus.START = 1'b0;
    check({t, "_done_seen"}, 32'(got_done), 32'd1);
    check({t, "_busy_cycles"}, 32'(busy_n), 32'(v.exp_busy));
    check({t, "_ssn_frame"}, 32'(ssn_bad), 32'd0);
    check({t, "_no_selerr"}, 32'(selerr_n), 32'd0);
    check({t, "_data_rx"}, 32'(bus.DATA_RX), 32'(v.exp_rx));
    check({t, "_sclk_idle"}, 32'(bus.SCLK), 32'(v.cpol));
    check({t, "_ssn_idle"}, 32'(bus.SS_N), 32'(3'b111));
    check({t, "_busy_low"}, 32'(bus.BUSY), 32'd0);
    check({t, "_mosi_hold"}, 32'(bus.MOSI), 32'(v.data_m[0]));
    @(negedge CLK);
    check({t, "_done_pulse"}, 32'(bus.DONE), 32'd0);
    check({t, "_rx_hold"}, 32'(bus.DATA_RX), 32'(v.exp_rx));
    check({t, "_slave_frames"}, 32'(s_q.size()), 32'd1);
    if (s_q.size() > 0) begin
      check({t, "_mosi_word"}, 32'(s_q.pop_front()), 32'(v.data_m));
      check({t, "_sample_edges"}, 32'(s_cnt_q.pop_front()), 32'(DW));
    end
    check({t, "_mosi_stable"}, 32'(s_unstable), 32'd0);
    s_q.delete();
    s_cnt_q.delete();
  endtask

  vec_t vecs[12];

  initial begin
    logic [DW-1:0] sent[$];
    logic [DW-1:0] cur_dm;
    int n_done, n_started, idle_n, busy_n, waited;
    logic prev_busy;

    vecs[0] = mk(1'b0, 1'b0, 0, 1, 8'hA5, 8'h00, 1'b1);
    vecs[1] = mk(1'b1, 1'b1, 3, 0, 8'h5A, 8'h3C, 1'b0);
    vecs[2] = mk(1'b0, 1'b1, 1, 2, 8'h69, 8'hC3, 1'b0);
    vecs[3] = mk(1'b1, 1'b0, 2, 0, 8'h81, 8'hC3, 1'b0);
    vecs[4] = mk(1'b0, 1'b0, 0, 2, 8'h33, 8'h96, 1'b0);
    vecs[5] = mk(1'b0, 1'b0, 1, 1, 8'h0F, 8'hF0, 1'b0);
    for (int i = 6; i < 12; i++)
      vecs[i] = mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                   $urandom_range(0, NSS - 1), DW'($urandom), DW'($urandom), 1'b0);

    bus.START = 1'b0; bus.SS_IN = '0; bus.CPOL = 1'b0; bus.CPHA = 1'b0;
    bus.CLK_DIV = '0; bus.DATA_M = '0;

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_ssn", 32'(bus.SS_N), 32'(3'b111));
    check("rst_sclk", 32'(bus.SCLK), 32'd0);
    check("rst_mosi", 32'(bus.MOSI), 32'd0);
    check("rst_rx", 32'(bus.DATA_RX), 32'd0);
    check("rst_flags", 32'({bus.BUSY, bus.DONE, bus.SEL_ERR}), 32'd0);
    RST_N = 1'b1;

    for (int i = 0; i < 12; i++) begin
      if (i == 4) begin
        // Invalid select: one-cycle SEL_ERR, nothing else moves.
        @(negedge CLK);
        bus.SS_IN = SSW'(3); bus.START = 1'b1;
        @(negedge CLK);
        bus.START = 1'b0;
        check("selerr_pulse", 32'(bus.SEL_ERR), 32'd1);
        check("selerr_ssn", 32'(bus.SS_N), 32'(3'b111));
        check("selerr_busy", 32'(bus.BUSY), 32'd0);
        @(negedge CLK);
        check("selerr_clear", 32'(bus.SEL_ERR), 32'd0);
        check("selerr_busy2", 32'(bus.BUSY), 32'd0);
      end
      if (i == 5) begin
        // Back-to-back: START held for three frames, DATA_M changed mid-frame.
        s_q.delete(); s_cnt_q.delete();
        @(negedge CLK);
        cur_cpha = 1'b0; r_loop = 1'b0; s_word = 8'h5C; cur_dm = 8'h11;
        bus.CPOL = 1'b0; bus.CPHA = 1'b0; bus.CLK_DIV = '0; bus.SS_IN = '0;
        bus.DATA_M = cur_dm; bus.START = 1'b1;
        n_done = 0; n_started = 0; idle_n = 0; busy_n = 0; prev_busy = 1'b0;
        for (int cyc = 0; cyc < 300 && n_done < 3; cyc++) begin
          @(negedge CLK);
          if (bus.BUSY && !prev_busy) begin
            sent.push_back(cur_dm);
            cur_dm = cur_dm + 8'h22;
            bus.DATA_M = cur_dm;
            n_started++;
          end
          prev_busy = bus.BUSY;
          if (bus.BUSY) busy_n++;
          if (bus.DONE) begin
            n_done++;
            if (n_done == 3) bus.START = 1'b0;
          end
          if (n_done < 3 && n_started > 0 && &bus.SS_N) idle_n++;
        end
        bus.START = 1'b0;
        check("b2b_done_count", 32'(n_done), 32'd3);
        check("b2b_starts", 32'(n_started), 32'd3);
        check("b2b_busy_total", 32'(busy_n), 32'(3 * (2 * DW + 2)));
        check("b2b_ss_gap", 32'(idle_n), 32'd2);
        check("b2b_rx", 32'(bus.DATA_RX), 32'(8'h5C));
        repeat (2) @(negedge CLK);
        check("b2b_no_extra", 32'(bus.BUSY), 32'd0);
        check("b2b_frames", 32'(s_q.size()), 32'd3);
        for (int f = 0; f < 3 && s_q.size() > 0 && sent.size() > 0; f++)
          check($sformatf("b2b_word%0d", f), 32'(s_q.pop_front()), 32'(sent.pop_front()));

        // Reset during edge 7 of a frame.
        s_q.delete(); s_cnt_q.delete();
        @(negedge CLK);
        bus.DATA_M = 8'hE7; bus.CLK_DIV = DIVW'(1); bus.SS_IN = SSW'(1); bus.START = 1'b1;
        @(negedge CLK);
        bus.START = 1'b0;
        waited = 0;
        while (s_e < 7 && waited < 200) begin
          @(negedge CLK);
          #1;
          waited++;
        end
        check("abort_edge7", 32'(s_e), 32'd7);
        #1 RST_N = 1'b0;
        #1;
        check("abort_ssn", 32'(bus.SS_N), 32'(3'b111));
        check("abort_sclk", 32'(bus.SCLK), 32'd0);
        check("abort_busy", 32'(bus.BUSY), 32'd0);
        check("abort_rx", 32'(bus.DATA_RX), 32'd0);
        check("abort_mosi", 32'(bus.MOSI), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        s_q.delete(); s_cnt_q.delete();
      end
      run_vec(vecs[i], i);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
